// File: rtl/spike_stim_gen.sv
`timescale 1ns/1ps
// spike_stim_gen: divided-rate signed 16-bit synthetic neural stream with a biphasic spike template.
// Optional macro STIM_NOISE_EN adds LFSR background noise; without it the noise term is 0.
module spike_stim_gen #(
  parameter int          CLK_DIV        = 4,
  parameter int          SPIKE_INTERVAL = 200,
  parameter int          SPIKE_AMP      = 1000,
  parameter int          NOISE_SHIFT    = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        spike_marker,
  output logic [15:0] spike_count
);

  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W      = $clog2(SPIKE_INTERVAL);
  localparam int SPK_START = SPIKE_INTERVAL - 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NOISE = 2'd1;
  localparam logic [1:0] S_SPIKE = 2'd2;

  localparam logic signed [16:0] AMP = 17'(SPIKE_AMP);

  generate
    if (CLK_DIV < 1)                           begin : g_chk_div  $error("CLK_DIV must be >= 1"); end
    if (SPIKE_INTERVAL < 16)                   begin : g_chk_int  $error("SPIKE_INTERVAL must be >= 16"); end
    if (NOISE_SHIFT < 0 || NOISE_SHIFT > 15)   begin : g_chk_shf  $error("NOISE_SHIFT must be 0..15"); end
    if (LFSR_SEED == 16'h0000)                 begin : g_chk_seed $error("LFSR_SEED must be nonzero"); end
  endgenerate

  logic [DIV_W-1:0]   div_q, div_d;
  logic [PH_W-1:0]    ph_q, ph_d, ph_nxt;
  logic [1:0]         state_q, state_d;
  logic [15:0]        data_out_q, data_out_d;
  logic [15:0]        count_q, count_d;
  logic               valid_q, valid_d;
  logic               marker_q, marker_d;
  logic               tick, in_spike;
  logic [2:0]         j;
  logic signed [16:0] tmpl, noise, sum;
  logic [15:0]        sat;

  assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
  assign in_spike = (state_q == S_SPIKE);
  assign j        = 3'(ph_q - PH_W'(SPK_START));
  assign ph_nxt   = (ph_q == PH_W'(SPIKE_INTERVAL - 1)) ? '0 : ph_q + 1'b1;

`ifdef STIM_NOISE_EN
  logic [15:0]        lfsr_q, lfsr_d;
  logic signed [15:0] noise16;

  // Sample uses the value before this tick's advance.
  assign noise16 = $signed(lfsr_q) >>> NOISE_SHIFT;
  assign noise   = {noise16[15], noise16};

  always_comb begin
    lfsr_d = lfsr_q;
    if (enable && tick)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign noise = '0;
`endif

  always_comb begin
    tmpl = '0;
    if (in_spike) begin
      case (j)
        3'd0:    tmpl = AMP >>> 2;
        3'd1:    tmpl = AMP;
        3'd2:    tmpl = AMP >>> 1;
        3'd3:    tmpl = -(AMP >>> 1);
        3'd4:    tmpl = -(AMP >>> 2);
        3'd5:    tmpl = -(AMP >>> 3);
        default: tmpl = '0;
      endcase
    end
  end

  // 17-bit sum cannot overflow; clamp back into 16-bit range.
  always_comb begin
    sum = noise + tmpl;
    if (sum[16] != sum[15]) sat = sum[16] ? 16'h8000 : 16'h7FFF;
    else                    sat = sum[15:0];
  end

  always_comb begin
    div_d      = div_q;
    ph_d       = ph_q;
    state_d    = state_q;
    data_out_d = data_out_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    marker_d   = 1'b0;
    if (!enable) begin
      // Abandon any partial template; LFSR and counter are kept.
      state_d    = S_IDLE;
      div_d      = '0;
      ph_d       = '0;
      data_out_d = '0;
    end else if (tick) begin
      div_d      = '0;
      ph_d       = ph_nxt;
      valid_d    = 1'b1;
      data_out_d = sat;
      marker_d   = in_spike && (j == 3'd0);
      if (in_spike && (j == 3'd0)) count_d = count_q + 16'd1;
      state_d    = (ph_nxt >= PH_W'(SPK_START)) ? S_SPIKE : S_NOISE;
    end else begin
      div_d   = div_q + 1'b1;
      state_d = (state_q == S_IDLE) ? S_NOISE : state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      ph_q       <= '0;
      state_q    <= S_IDLE;
      data_out_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      marker_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      ph_q       <= ph_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      marker_q   <= marker_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = valid_q;
  assign spike_marker = marker_q;
  assign spike_count  = count_q;

endmodule
